// File: rtl/lsu_handshake_if.sv
// Handshake bundle between exu, the memory-access stage, data memory and wbu.
interface lsu_handshake_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    e_regW;
  logic [ADDR_WIDTH-1:0]   e_regAddr;
  logic [DATA_WIDTH-1:0]   e_regData;
  logic [2:0]              e_load_inst;
  logic [3:0]              e_store_mask;
  logic [DATA_WIDTH-1:0]   e_store_data;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [DATA_WIDTH-1:0]   mem_req_addr;
  logic                    mem_req_wen;
  logic [3:0]              mem_req_wstrb;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_resp_rdata;

  logic                    out_valid;
  logic                    out_ready;
  logic                    m_regW;
  logic [ADDR_WIDTH-1:0]   m_regAddr;
  logic [DATA_WIDTH-1:0]   m_regData;
  logic                    misalign;

  // The stage side.
  modport slave (
    input  in_valid, e_regW, e_regAddr, e_regData, e_load_inst, e_store_mask, e_store_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
    output out_valid, m_regW, m_regAddr, m_regData, misalign
  );

  // The environment side (exu, memory and wbu together).
  modport master (
    output in_valid, e_regW, e_regAddr, e_regData, e_load_inst, e_store_mask, e_store_data,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
    input  out_valid, m_regW, m_regAddr, m_regData, misalign
  );
endinterface

// File: rtl/lsu_handshake.sv
// Memory-access pipeline stage: pass-through, load or store over a req/resp data-memory port.
// One operation in flight; all outputs come straight from registers.
module lsu_handshake #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  lsu_handshake_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                    req_wen_q, req_wen_d;
  logic [3:0]              req_wstrb_q, req_wstrb_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic                    out_valid_q, out_valid_d;
  logic                    regw_q, regw_d;
  logic [ADDR_WIDTH-1:0]   regaddr_q, regaddr_d;
  logic [DATA_WIDTH-1:0]   regdata_q, regdata_d;
  logic                    misalign_q, misalign_d;
  logic [2:0]              ld_q, ld_d;
  logic [1:0]              off_q, off_d;

  logic [1:0] off;
  logic       is_load;
  logic       is_store;
  logic       misal;

  // Byte/half/word select from the read word, then sign or zero extension.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] ld,
                                                        input logic [1:0] ofs,
                                                        input logic [DATA_WIDTH-1:0] word);
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {ofs, 3'b000};
    case (ld)
      3'd1:    load_extend = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'd2:    load_extend = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'd3:    load_extend = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'd4:    load_extend = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // Decode of the operation presented by exu; a load wins over a store.
  always_comb begin
    off      = bus.e_regData[1:0];
    is_load  = (bus.e_load_inst != 3'd0) && (bus.e_load_inst < 3'd6);
    is_store = !is_load && (bus.e_store_mask != 4'd0);
    misal    = 1'b0;
    if (is_load) begin
      if (bus.e_load_inst == 3'd3 || bus.e_load_inst == 3'd4) misal = off[0];
      else if (bus.e_load_inst == 3'd5)                       misal = (off != 2'd0);
    end else if (is_store) begin
      if (bus.e_store_mask[3])      misal = (off != 2'd0);
      else if (bus.e_store_mask[1]) misal = off[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    out_valid_d = out_valid_q;
    regw_d      = regw_q;
    regaddr_d   = regaddr_q;
    regdata_d   = regdata_q;
    misalign_d  = misalign_q;
    ld_d        = ld_q;
    off_d       = off_q;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          regaddr_d  = bus.e_regAddr;
          ld_d       = is_load ? bus.e_load_inst : 3'd0;
          off_d      = off;
          misalign_d = 1'b0;
          if (misal) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            misalign_d  = 1'b1;
            regw_d      = 1'b0;
            regdata_d   = bus.e_regData;
          end else if (is_load || is_store) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {bus.e_regData[DATA_WIDTH-1:2], 2'b00};
            req_wen_d   = is_store;
            req_wstrb_d = is_store ? 4'(bus.e_store_mask << off) : 4'd0;
            req_wdata_d = is_store ? DATA_WIDTH'(bus.e_store_data << {off, 3'b000})
                                   : '0;
            regw_d      = bus.e_regW & is_load;
            regdata_d   = '0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            regw_d      = bus.e_regW;
            regdata_d   = bus.e_regData;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (ld_q != 3'd0) regdata_d = load_extend(ld_q, off_q, bus.mem_resp_rdata);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wstrb_q <= 4'd0;
      req_wdata_q <= '0;
      out_valid_q <= 1'b0;
      regw_q      <= 1'b0;
      regaddr_q   <= '0;
      regdata_q   <= '0;
      misalign_q  <= 1'b0;
      ld_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      out_valid_q <= out_valid_d;
      regw_q      <= regw_d;
      regaddr_q   <= regaddr_d;
      regdata_q   <= regdata_d;
      misalign_q  <= misalign_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_wstrb = req_wstrb_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.m_regW        = regw_q;
  assign bus.m_regAddr     = regaddr_q;
  assign bus.m_regData     = regdata_q;
  assign bus.misalign      = misalign_q;

endmodule
